// File: rtl/sys_defs.sv
// Shared PE-array definitions: packet layouts, precisions, ofmap sizes per operating mode.
package sys_defs;

  localparam int PSUM_DATA_SIZE = 16;
  localparam int IFDATA_SIZE    = 8;
  localparam int L1_OFMAP_SIZE  = 32;
  localparam int L2_OFMAP_SIZE  = 8;
  localparam int L3_OFMAP_SIZE  = 4;
  localparam int NUM_FILTER     = 4;
  localparam int POS_CNT_SIZE   = 7;
  localparam int OUT_POS_SIZE   = 6;
  localparam int OUT_COL_SIZE   = 2;

  typedef enum logic [1:0] {MODE1, MODE2, MODE3, MODE4} OP_MODE;

  typedef struct packed {
    logic                      valid;
    logic [PSUM_DATA_SIZE-1:0] psum;
    logic [1:0]                filter_idx;
  } PSUM_PACKET;

  typedef struct packed {
    logic                    valid;
    logic [IFDATA_SIZE-1:0]  data;
    logic [OUT_COL_SIZE-1:0] col;
    logic [1:0]              filter;
    logic [OUT_POS_SIZE-1:0] pos;
  } OFMAP_PACKET;

  // Last valid ofmap position index for the given mode.
  function automatic logic [POS_CNT_SIZE-1:0] psum_idx_max(input OP_MODE m);
    case (m)
      MODE3:   return POS_CNT_SIZE'(L2_OFMAP_SIZE - 1);
      MODE4:   return POS_CNT_SIZE'(L3_OFMAP_SIZE - 1);
      default: return POS_CNT_SIZE'(L1_OFMAP_SIZE - 1);
    endcase
  endfunction

endpackage

// File: rtl/psum_collector_ofmap_fifo.sv
// First-word-fall-through FIFO holding tagged ofmap entries on their way to the global buffer.
module ofmap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/psum_collector.sv
// Collects column psums round-robin, applies ReLU + requantization, tags and buffers them,
// and flags completion of every (column, filter) position set for the current mode.
module psum_collector
  import sys_defs::*;
#(
  parameter int NUM_COL    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_SHIFT  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  OP_MODE                     mode_in,
  input  logic                       change_mode,
  input  logic                       conv_continue,
  input  PSUM_PACKET [NUM_COL-1:0]   psum_in,
  output logic [NUM_COL-1:0]         psum_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IFDATA_SIZE-1:0]     out_data,
  output logic [$clog2(NUM_COL)-1:0] out_col,
  output logic [1:0]                 out_filter,
  output logic [OUT_POS_SIZE-1:0]    out_pos,
  output logic                       conv_done,
  output logic                       error
);

  localparam int COL_W = $clog2(NUM_COL);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PSUM_DATA_SIZE-1:0] QMAX = PSUM_DATA_SIZE'(2**(IFDATA_SIZE-1) - 1);

  OP_MODE                    mode_reg;
  logic [COL_W-1:0]          rr_ptr_reg;
  logic                      error_reg;
  logic                      done_reg;
  logic [POS_CNT_SIZE-1:0]   pos_cnt_reg [NUM_COL][NUM_FILTER];
  logic [NUM_COL*NUM_FILTER-1:0] cnt_full;
  logic [POS_CNT_SIZE-1:0]   idx_max;
  logic [POS_CNT_SIZE-1:0]   idx_full;

  logic                      stage_valid_reg;
  logic [PSUM_DATA_SIZE-1:0] stage_psum_reg;
  logic [COL_W-1:0]          stage_col_reg;
  logic [1:0]                stage_filter_reg;
  logic [OUT_POS_SIZE-1:0]   stage_pos_reg;

  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W:0]            occupancy;
  logic                      can_grant;
  logic                      grant_any;
  logic [COL_W-1:0]          grant_idx;
  logic [1:0]                sel_filter;
  logic [POS_CNT_SIZE-1:0]   sel_cnt;
  logic                      sel_over;

  logic [PSUM_DATA_SIZE-1:0] relu_psum;
  logic [PSUM_DATA_SIZE-1:0] shifted_psum;
  logic [IFDATA_SIZE-1:0]    q_data;
  OFMAP_PACKET               wr_pkt;
  OFMAP_PACKET               rd_pkt;

  assign idx_max   = psum_idx_max(mode_reg);
  assign idx_full  = idx_max + POS_CNT_SIZE'(1);
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid_reg};
  assign can_grant = !rst && !conv_continue && !change_mode &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  // Search starts one past the last winner so every column gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr_reg;
    for (int k = 1; k <= NUM_COL; k++) begin
      if (!grant_any && can_grant &&
          psum_in[COL_W'((int'(rr_ptr_reg) + k) % NUM_COL)].valid) begin
        grant_any = 1'b1;
        grant_idx = COL_W'((int'(rr_ptr_reg) + k) % NUM_COL);
      end
    end
  end

  always_comb begin
    psum_ack = '0;
    if (grant_any) psum_ack[grant_idx] = 1'b1;
  end

  assign sel_filter = psum_in[grant_idx].filter_idx;
  assign sel_cnt    = pos_cnt_reg[grant_idx][sel_filter];
  assign sel_over   = sel_cnt > idx_max;

  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col
    for (genvar gf = 0; gf < NUM_FILTER; gf++) begin : g_filt
      // Overflowing packets leave the counter parked at its full value.
      always_ff @(posedge clk) begin
        if (rst || conv_continue || change_mode) begin
          pos_cnt_reg[gi][gf] <= '0;
        end else if (grant_any && !sel_over && grant_idx == COL_W'(gi) &&
                     sel_filter == 2'(gf)) begin
          pos_cnt_reg[gi][gf] <= sel_cnt + POS_CNT_SIZE'(1);
        end
      end
      assign cnt_full[gi*NUM_FILTER+gf] = (pos_cnt_reg[gi][gf] == idx_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_reg  <= 1'b0;
      stage_psum_reg   <= '0;
      stage_col_reg    <= '0;
      stage_filter_reg <= '0;
      stage_pos_reg    <= '0;
    end else begin
      stage_valid_reg <= grant_any && !sel_over;
      if (grant_any) begin
        stage_psum_reg   <= psum_in[grant_idx].psum;
        stage_col_reg    <= grant_idx;
        stage_filter_reg <= sel_filter;
        stage_pos_reg    <= sel_cnt[OUT_POS_SIZE-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg   <= MODE1;
      rr_ptr_reg <= COL_W'(NUM_COL - 1);
      error_reg  <= 1'b0;
      done_reg   <= 1'b1;
    end else begin
      if (change_mode) mode_reg <= mode_in;
      if (grant_any) rr_ptr_reg <= grant_idx;
      if (conv_continue)              error_reg <= 1'b0;
      else if (grant_any && sel_over) error_reg <= 1'b1;
      if (conv_continue || change_mode) done_reg <= 1'b0;
      else if ((&cnt_full) && !stage_valid_reg && fifo_count == '0) done_reg <= 1'b1;
    end
  end

  assign relu_psum    = stage_psum_reg[PSUM_DATA_SIZE-1] ? '0 : stage_psum_reg;
  assign shifted_psum = relu_psum >> OUT_SHIFT;
  assign q_data       = (shifted_psum > QMAX) ? QMAX[IFDATA_SIZE-1:0]
                                              : shifted_psum[IFDATA_SIZE-1:0];

  always_comb begin
    wr_pkt        = '0;
    wr_pkt.valid  = 1'b1;
    wr_pkt.data   = q_data;
    wr_pkt.col    = OUT_COL_SIZE'(stage_col_reg);
    wr_pkt.filter = stage_filter_reg;
    wr_pkt.pos    = stage_pos_reg;
  end

  ofmap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(OFMAP_PACKET))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (stage_valid_reg),
    .wr_data (wr_pkt),
    .pop     (out_valid && out_ready),
    .rd_data (rd_pkt),
    .count   (fifo_count)
  );

  // Outputs are forced to zero while empty so stale RAM contents never leak out.
  assign out_valid  = (fifo_count != '0) && rd_pkt.valid;
  assign out_data   = out_valid ? rd_pkt.data : '0;
  assign out_col    = out_valid ? COL_W'(rd_pkt.col) : '0;
  assign out_filter = out_valid ? rd_pkt.filter : '0;
  assign out_pos    = out_valid ? rd_pkt.pos : '0;
  assign conv_done  = done_reg;
  assign error      = error_reg;

endmodule
